// File: rtl/cache_line_ctrl.sv
// Miss sequencer and memory-port arbiter for a bank of cache_line instances.
// Picks the lowest-TTL victim on a global miss and sequences fills, flushes and flush-all.
module cache_line_ctrl #(
    parameter int ADDRBITS = 32,
    parameter int LSBBITS  = 7,
    parameter int TTLBITS  = 8,
    parameter int NLINES   = 4,
    parameter int IDXBITS  = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid,
    input  logic [ADDRBITS-1:0]         req_addr,
    input  logic [NLINES-1:0]           line_miss,
    input  logic [NLINES-1:0]           line_ready,
    input  logic [NLINES-1:0]           line_dirty,
    input  logic [NLINES*TTLBITS-1:0]   line_ttl,
    output logic [NLINES-1:0]           line_fill,
    output logic [NLINES-1:0]           line_flush,
    output logic [ADDRBITS-1:0]         new_region,
    output logic [NLINES-1:0]           line_pause,
    output logic [IDXBITS-1:0]          mem_sel,
    input  logic                        mem_busy,
    input  logic                        flush_all_req,
    output logic                        flush_all_done,
    output logic                        ctrl_busy
);

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT_DROP, WAIT_DONE, FA_SCAN, FA_ISSUE, FA_DROP, FA_WAIT
    } state_t;

    localparam logic [IDXBITS-1:0]  LAST_IDX    = IDXBITS'(NLINES - 1);
    localparam logic [ADDRBITS-1:0] REGION_MASK = {{(ADDRBITS-LSBBITS){1'b1}}, {LSBBITS{1'b0}}};

    state_t                 r_state;
    logic [IDXBITS-1:0]     r_mem_sel;
    logic [IDXBITS-1:0]     r_idx;
    logic [NLINES-1:0]      r_fill;
    logic [NLINES-1:0]      r_flush;
    logic [ADDRBITS-1:0]    r_new_region;
    logic                   r_done;
    logic                   r_busy;

    logic                   w_miss;
    logic [IDXBITS-1:0]     w_victim;
    logic [TTLBITS-1:0]     w_min_ttl;
    logic [NLINES-1:0]      w_victim_oh;
    logic [NLINES-1:0]      w_idx_oh;
    logic                   w_sel_ready;
    logic                   w_waiting;

    assign w_miss      = req_valid & (&line_miss) & (&line_ready);
    assign w_victim_oh = NLINES'(1) << w_victim;
    assign w_idx_oh    = NLINES'(1) << r_idx;
    assign w_sel_ready = line_ready[r_mem_sel];
    assign w_waiting   = r_state inside {WAIT_DROP, WAIT_DONE, FA_DROP, FA_WAIT};

    // Strict less-than keeps the lowest index on TTL ties.
    always_comb begin
        w_victim  = '0;
        w_min_ttl = line_ttl[0 +: TTLBITS];
        for (int unsigned i = 1; i < NLINES; i++) begin
            if (line_ttl[i*TTLBITS +: TTLBITS] < w_min_ttl) begin
                w_min_ttl = line_ttl[i*TTLBITS +: TTLBITS];
                w_victim  = IDXBITS'(i);
            end
        end
    end

    always_comb begin
        line_pause = '0;
        if (mem_busy && w_waiting) begin
            line_pause[r_mem_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_mem_sel    <= '0;
            r_idx        <= '0;
            r_fill       <= '0;
            r_flush      <= '0;
            r_new_region <= '0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_fill  <= '0;
            r_flush <= '0;
            r_done  <= 1'b0;
            case (r_state)
                // Command pulses are registered on entry so they are high exactly during ISSUE.
                IDLE: begin
                    if (w_miss) begin
                        r_state      <= ISSUE;
                        r_busy       <= 1'b1;
                        r_mem_sel    <= w_victim;
                        r_new_region <= req_addr & REGION_MASK;
                        r_fill       <= w_victim_oh;
                        if (line_dirty[w_victim]) begin
                            r_flush <= w_victim_oh;
                        end
                    end else if (flush_all_req) begin
                        r_state <= FA_SCAN;
                        r_busy  <= 1'b1;
                        r_idx   <= '0;
                    end
                end
                ISSUE: begin
                    r_state <= WAIT_DROP;
                end
                WAIT_DROP: begin
                    if (!w_sel_ready) begin
                        r_state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (w_sel_ready) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                FA_SCAN: begin
                    if (line_dirty[r_idx]) begin
                        r_state   <= FA_ISSUE;
                        r_mem_sel <= r_idx;
                        r_flush   <= w_idx_oh;
                    end else if (r_idx == LAST_IDX) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                FA_ISSUE: begin
                    r_state <= FA_DROP;
                end
                FA_DROP: begin
                    if (!w_sel_ready) begin
                        r_state <= FA_WAIT;
                    end
                end
                FA_WAIT: begin
                    if (w_sel_ready) begin
                        if (r_idx == LAST_IDX) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= FA_SCAN;
                            r_idx   <= r_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign line_fill      = r_fill;
    assign line_flush     = r_flush;
    assign new_region     = r_new_region;
    assign mem_sel        = r_mem_sel;
    assign flush_all_done = r_done;
    assign ctrl_busy      = r_busy;

endmodule
